// File: rtl/jt1942_rom_sched.sv
// Shares one registered-read 16-bit ROM port among NPORT requesters (round-robin) and passes download writes through.
// Optional fixed port-0 priority: define JT1942_ROMSCHED_PRIO0_EN.
module jt1942_rom_sched #(
    parameter int NPORT = 5,
    parameter int AW    = 21,
    parameter int LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [15:0]         prog_data,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT*AW-1:0] addr,
    output logic [NPORT-1:0]    data_ok,
    output logic [NPORT*16-1:0] dout,
    output logic [AW-1:0]       rom_addr,
    output logic                rom_we,
    output logic [15:0]         rom_din,
    input  logic [15:0]         rom_q
);
    localparam int PW = $clog2(NPORT);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PW-1:0] LAST = PW'(NPORT-1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    rr;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    sel_next;
    logic [AW-1:0]    sel_addr;
    logic [NPORT-1:0] valid;
    logic [NPORT-1:0] hit;
    logic [NPORT-1:0] pending;
    logic [AW-1:0]    last_addr [NPORT];
    logic [AW-1:0]    port_addr [NPORT];
    logic [15:0]      dout_q    [NPORT];
    logic             we_q;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            port_addr[i]     = addr[i*AW +: AW];
            hit[i]           = valid[i] && (port_addr[i] == last_addr[i]);
            dout[i*16 +: 16] = dout_q[i];
        end
    end

    assign data_ok  = downloading ? '0 : (req & hit);
    assign pending  = req & ~hit;
    // Gated so a write registered on the last download cycle never leaks out afterwards.
    assign rom_we   = we_q & downloading;
    assign sel_next = (sel == LAST) ? '0 : sel + 1'b1;

    // First pending port at or above rr, wrapping; scanning downward lets the nearest one win.
    always_comb begin
        logic [PW:0] cand;
        pick = rr;
        cand = '0;
        for (int k = NPORT-1; k >= 0; k--) begin
            cand = {1'b0, rr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NPORT)) cand = cand - (PW+1)'(NPORT);
            if (pending[cand[PW-1:0]]) pick = cand[PW-1:0];
        end
`ifdef JT1942_ROMSCHED_PRIO0_EN
        if (pending[0]) pick = '0;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= '0;
            sel_addr <= '0;
            rr       <= '0;
            valid    <= '0;
            rom_addr <= '0;
            rom_din  <= '0;
            we_q     <= 1'b0;
            for (int i = 0; i < NPORT; i++) begin
                last_addr[i] <= '0;
                dout_q[i]    <= '0;
            end
        end else if (downloading) begin
            we_q     <= prog_we;
            rom_addr <= prog_addr;
            rom_din  <= prog_data;
            state    <= IDLE;
            valid    <= '0;
            rr       <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        rom_addr     <= port_addr[pick];
                        sel          <= pick;
                        sel_addr     <= port_addr[pick];
                        valid[pick]  <= 1'b0;
                        cnt          <= CW'(LAT-1);
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= CAPT;
                    else           cnt   <= cnt - 1'b1;
                end
                CAPT: begin
                    dout_q[sel]    <= rom_q;
                    last_addr[sel] <= sel_addr;
                    valid[sel]     <= 1'b1;
`ifdef JT1942_ROMSCHED_PRIO0_EN
                    if (sel != '0) rr <= sel_next;
`else
                    rr <= sel_next;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
